// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lamp codes and sequencer state encoding
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_e;

endpackage

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - loadable down-counter with enable and zero flag
module interval_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= RST_VAL;
    end else if (en) begin
      if (load) count_q <= load_val;
      else      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - round-robin demand-actuated phase sequencer with amber flash
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int CNT_W       = 8,
  parameter int GREEN_TIME  = 5,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int FLASH_HALF  = 4,
  localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    flash_req,
  input  logic [NUM_PHASES-1:0]   req,
  output logic [3*NUM_PHASES-1:0] lights,
  output logic [CNT_W-1:0]        count,
  output logic [PW-1:0]           phase,
  output logic                    flashing
);

  state_e                  state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d, rr_phase, cand;
  logic                    flash_on_q, flash_on_d, found;
  logic [3*NUM_PHASES-1:0] lights_q, lights_d;
  logic                    flashing_q;
  logic                    tmr_load, tmr_zero;
  logic [CNT_W-1:0]        tmr_load_val;

  interval_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(CNT_W'(ALLRED_TIME - 1))
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .count   (count),
    .zero    (tmr_zero)
  );

  // First requesting phase after the current one; plain increment when nobody asks.
  always_comb begin
    rr_phase = PW'((int'(phase_q) + 1) % NUM_PHASES);
    cand     = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      cand = PW'((int'(phase_q) + k) % NUM_PHASES);
      if (!found && req[cand]) begin
        rr_phase = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    flash_on_d   = flash_on_q;
    tmr_load     = tmr_zero;
    tmr_load_val = '0;
    if (tmr_zero) begin
      case (state_q)
        ST_GREEN: begin
          state_d      = ST_YELLOW;
          tmr_load_val = CNT_W'(YELLOW_TIME - 1);
        end
        ST_YELLOW: begin
          state_d      = ST_ALLRED;
          tmr_load_val = CNT_W'(ALLRED_TIME - 1);
        end
        ST_ALLRED: begin
          if (flash_req) begin
            state_d      = ST_FLASH;
            flash_on_d   = 1'b1;
            tmr_load_val = CNT_W'(FLASH_HALF - 1);
          end else begin
            state_d      = ST_GREEN;
            phase_d      = rr_phase;
            tmr_load_val = CNT_W'(GREEN_TIME - 1);
          end
        end
        default: begin
          if (flash_req) begin
            flash_on_d   = ~flash_on_q;
            tmr_load_val = CNT_W'(FLASH_HALF - 1);
          end else begin
            state_d      = ST_ALLRED;
            phase_d      = PW'(NUM_PHASES - 1);
            tmr_load_val = CNT_W'(ALLRED_TIME - 1);
          end
        end
      endcase
    end
  end

  always_comb begin
    lights_d = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (state_d == ST_FLASH)
        lights_d[3*i +: 3] = flash_on_d ? LIGHT_YELLOW : LIGHT_OFF;
      else if (PW'(i) == phase_d && state_d == ST_GREEN)
        lights_d[3*i +: 3] = LIGHT_GREEN;
      else if (PW'(i) == phase_d && state_d == ST_YELLOW)
        lights_d[3*i +: 3] = LIGHT_YELLOW;
      else
        lights_d[3*i +: 3] = LIGHT_RED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_ALLRED;
      phase_q    <= PW'(NUM_PHASES - 1);
      flash_on_q <= 1'b0;
      lights_q   <= {NUM_PHASES{LIGHT_RED}};
      flashing_q <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      flash_on_q <= flash_on_d;
      lights_q   <= lights_d;
      flashing_q <= (state_d == ST_FLASH);
    end
  end

  assign lights   = lights_q;
  assign phase    = phase_q;
  assign flashing = flashing_q;

endmodule
